// File: rtl/gray_seq_checker.sv
// gray_seq_checker: decodes a Gray-coded word stream back to binary through
// a 2-stage pipeline. It checks that the words form a +1 sequence, runs an
// IDLE/ACQ/TRACK lock FSM, and keeps error and word counters.
// Optional feature macro: GRAY_HD_CHECK_EN adds o_hd_err, which flags
// consecutive Gray words whose Hamming distance is not exactly 1.
module gray_seq_checker #(
  parameter int DW     = 8,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_vld,
  input  logic [DW-1:0] i_gray,
  output logic          o_vld,
  output logic [DW-1:0] o_bin,
  output logic          o_locked,
  output logic          o_err,
  output logic [15:0]   o_err_cnt,
  output logic [15:0]   o_word_cnt
`ifdef GRAY_HD_CHECK_EN
  ,
  output logic          o_hd_err
`endif
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_N);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  state_t        state;
  logic          s1_vld;
  logic [DW-1:0] s1_gray;
  logic [DW-1:0] dec;
  logic [DW-1:0] ref_bin;
  logic          ref_ok;
  logic [3:0]    good;
  logic [3:0]    bad;
  logic [3:0]    good_inc;
  logic [3:0]    bad_inc;
  logic          seq;

`ifdef GRAY_HD_CHECK_EN
  logic [DW-1:0] ref_gray;
  logic [DW-1:0] hd_diff;
  logic          hd_one;
`endif

  // Gray-to-binary decode of the S1 word and the +1 sequence test against the reference.
  // Each binary bit is the XOR of all Gray bits at or above it, built as a sum of shifts.
  always_comb begin
    dec = s1_gray;
    for (int unsigned s = 1; s < DW; s++) begin
      dec = dec ^ (s1_gray >> s);
    end
    seq      = ref_ok && (dec == DW'(ref_bin + DW'(1)));
    good_inc = good + 4'd1;
    bad_inc  = bad + 4'd1;
  end

`ifdef GRAY_HD_CHECK_EN
  // Exactly one differing bit between the S1 word and the previous Gray word.
  always_comb begin
    hd_diff = s1_gray ^ ref_gray;
    hd_one  = (hd_diff != '0) && ((hd_diff & (hd_diff - DW'(1))) == '0);
  end
`endif

  // Data pipeline: S1 capture, S2 decoded output. Not affected by i_clr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld  <= 1'b0;
      s1_gray <= '0;
      o_vld   <= 1'b0;
      o_bin   <= '0;
    end else begin
      s1_vld  <= i_vld;
      s1_gray <= i_gray;
      o_vld   <= s1_vld;
      o_bin   <= dec;
    end
  end

  // Lock FSM, reference register, error pulse and statistics counters (all registered).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ref_ok     <= 1'b0;
      ref_bin    <= '0;
      good       <= '0;
      bad        <= '0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_word_cnt <= '0;
`ifdef GRAY_HD_CHECK_EN
      ref_gray   <= '0;
      o_hd_err   <= 1'b0;
`endif
    end else begin
      o_err <= 1'b0;
`ifdef GRAY_HD_CHECK_EN
      o_hd_err <= 1'b0;
`endif
      // The reference always follows the latest word; after a clear ref_ok
      // is low, so the stale value is never compared against.
      if (s1_vld) begin
        ref_bin <= dec;
`ifdef GRAY_HD_CHECK_EN
        ref_gray <= s1_gray;
`endif
      end
      if (i_clr) begin
        state      <= IDLE;
        ref_ok     <= 1'b0;
        good       <= '0;
        bad        <= '0;
        o_locked   <= 1'b0;
        o_err_cnt  <= '0;
        o_word_cnt <= '0;
      end else if (s1_vld) begin
        o_word_cnt <= o_word_cnt + 16'd1;
`ifdef GRAY_HD_CHECK_EN
        o_hd_err <= ref_ok && !hd_one;
`endif
        case (state)
          IDLE: begin
            ref_ok <= 1'b1;
            good   <= '0;
            state  <= ACQ;
          end
          ACQ: begin
            if (seq) begin
              if (good_inc == LOCK_CNT) begin
                state    <= TRACK;
                bad      <= '0;
                o_locked <= 1'b1;
              end
              good <= good_inc;
            end else begin
              good <= '0;
            end
          end
          TRACK: begin
            if (seq) begin
              bad <= '0;
            end else begin
              o_err <= 1'b1;
              if (o_err_cnt != '1) begin
                o_err_cnt <= o_err_cnt + 16'd1;
              end
              if (bad_inc == LOSS_CNT) begin
                state    <= ACQ;
                good     <= '0;
                bad      <= '0;
                o_locked <= 1'b0;
              end else begin
                bad <= bad_inc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Testbench for gray_seq_checker: a hand-written vector table, directed
// scenarios and randomized traffic checked against a behavioural model.
module tb_gray_seq_checker;
  localparam int DW     = 8;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          vld = 1'b0;
  logic [DW-1:0] gray = '0;
  logic          o_vld;
  logic [DW-1:0] o_bin;
  logic          o_locked;
  logic          o_err;
  logic [15:0]   o_err_cnt;
  logic [15:0]   o_word_cnt;
`ifdef GRAY_HD_CHECK_EN
  logic          o_hd_err;
`endif

  gray_seq_checker #(.DW(DW), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_vld(vld), .i_gray(gray),
    .o_vld(o_vld), .o_bin(o_bin), .o_locked(o_locked), .o_err(o_err),
    .o_err_cnt(o_err_cnt), .o_word_cnt(o_word_cnt)
`ifdef GRAY_HD_CHECK_EN
    , .o_hd_err(o_hd_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  int         inv[256];
  bit         m_prev_vld;
  logic [7:0] m_prev_gray;
  bit         m_has_ref;
  bit         m_locked;
  int         m_ref_bin;
  logic [7:0] m_ref_gray;
  int         m_run, m_miss, m_ec, m_wc;
  bit         e_vld, e_err, e_hd;
  int         e_bin;

  typedef struct {
    bit v; int b;
    bit x_vld; int x_bin; bit x_lock; bit x_err; int x_ec; int x_wc;
  } vec_t;
  vec_t tbl[13];

  int pulses;
  int val;
  int last;
  int w;
  bit rv, rc;

  function automatic logic [7:0] gry(input int b);
    return 8'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_prev_vld = 0; m_prev_gray = '0; m_has_ref = 0; m_locked = 0;
    m_ref_bin = 0; m_ref_gray = '0; m_run = 0; m_miss = 0; m_ec = 0; m_wc = 0;
  endfunction

  // One clock edge of the model: the previous cycle's word is judged with this cycle's clear.
  function automatic void model_edge(input bit cv, input logic [7:0] cg, input bit cc);
    int b;
    e_vld = m_prev_vld;
    e_bin = inv[m_prev_gray];
    e_err = 0;
    e_hd  = 0;
    if (cc) begin
      m_has_ref = 0; m_locked = 0; m_run = 0; m_miss = 0; m_ec = 0; m_wc = 0;
    end else if (m_prev_vld) begin
      b = inv[m_prev_gray];
      m_wc = (m_wc + 1) % 65536;
      if (!m_has_ref) begin
        m_has_ref = 1;
        m_run = 0;
      end else begin
        e_hd = ($countones(m_prev_gray ^ m_ref_gray) != 1);
        if (b == (m_ref_bin + 1) % 256) begin
          if (m_locked) m_miss = 0;
          else begin
            m_run++;
            if (m_run == LOCK_N) begin m_locked = 1; m_miss = 0; end
          end
        end else if (m_locked) begin
          e_err = 1;
          if (m_ec < 65535) m_ec++;
          m_miss++;
          if (m_miss == LOSS_N) begin m_locked = 0; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      m_ref_bin = b;
      m_ref_gray = m_prev_gray;
    end
    m_prev_vld = cv;
    m_prev_gray = cg;
  endfunction

  task automatic check_model();
    chk("vld", o_vld, e_vld);
    if (e_vld) chk("bin", o_bin, e_bin);
    chk("locked", o_locked, m_locked);
    chk("err", o_err, e_err);
    chk("err_cnt", o_err_cnt, m_ec);
    chk("word_cnt", o_word_cnt, m_wc);
`ifdef GRAY_HD_CHECK_EN
    chk("hd_err", o_hd_err, e_hd);
`endif
  endtask

  task automatic cycle(input bit v, input int b, input bit c, input bit check);
    vld = v; gray = gry(b); clr = c;
    @(posedge clk);
    model_edge(v, gry(b), c);
    #1;
    if (check) check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vld"}, o_vld, 0);
    chk({tag, "_bin"}, o_bin, 0);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_err_cnt"}, o_err_cnt, 0);
    chk({tag, "_word_cnt"}, o_word_cnt, 0);
`ifdef GRAY_HD_CHECK_EN
    chk({tag, "_hd_err"}, o_hd_err, 0);
`endif
  endtask

  // Called #1 after a rising edge; asserts reset asynchronously.
  task automatic do_reset(input int n);
    rst_n = 1'b0; vld = 1'b0; clr = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv[gry(i)] = i;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Hand-derived vectors: outputs after each edge reflect the previous row's word
    tbl[0]  = '{1, 0,  0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 1,  1, 0,  0, 0, 0, 1};
    tbl[2]  = '{1, 2,  1, 1,  0, 0, 0, 2};
    tbl[3]  = '{1, 3,  1, 2,  0, 0, 0, 3};
    tbl[4]  = '{1, 4,  1, 3,  0, 0, 0, 4};
    tbl[5]  = '{1, 5,  1, 4,  1, 0, 0, 5};
    tbl[6]  = '{1, 7,  1, 5,  1, 0, 0, 6};
    tbl[7]  = '{1, 8,  1, 7,  1, 1, 1, 7};
    tbl[8]  = '{0, 0,  1, 8,  1, 0, 1, 8};
    tbl[9]  = '{1, 20, 0, 0,  1, 0, 1, 8};
    tbl[10] = '{1, 30, 1, 20, 1, 1, 2, 9};
    tbl[11] = '{0, 0,  1, 30, 0, 1, 3, 10};
    tbl[12] = '{0, 0,  0, 0,  0, 0, 3, 10};
    for (int r = 0; r < 13; r++) begin
      cycle(tbl[r].v, tbl[r].b, 0, 0);
      chk("tbl_vld", o_vld, tbl[r].x_vld);
      if (tbl[r].x_vld) chk("tbl_bin", o_bin, tbl[r].x_bin);
      chk("tbl_locked", o_locked, tbl[r].x_lock);
      chk("tbl_err", o_err, tbl[r].x_err);
      chk("tbl_err_cnt", o_err_cnt, tbl[r].x_ec);
      chk("tbl_word_cnt", o_word_cnt, tbl[r].x_wc);
    end

    // Clean ramp 0..255 then 0
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      cycle(1, i, 0, 1);
      if (i == 4) chk("ramp_not_yet_locked", o_locked, 0);
      if (i == 5) chk("ramp_locked_after_5th", o_locked, 1);
    end
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("ramp_word_cnt", o_word_cnt, 257);
    chk("ramp_err_cnt", o_err_cnt, 0);
    chk("ramp_locked", o_locked, 1);

    // Single skip while locked
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i != 21) begin
        cycle(1, i, 0, 1);
        if (o_err) begin pulses++; chk("skip_err_bin", o_bin, 22); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 1);
      if (o_err) pulses++;
    end
    chk("skip_pulses", pulses, 1);
    chk("skip_err_cnt", o_err_cnt, 1);
    chk("skip_locked", o_locked, 1);

    // Loss and relock
    cycle(1, 40, 0, 1);
    cycle(1, 50, 0, 1);
    chk("loss_err_40", o_err, 1);
    cycle(1, 60, 0, 1);
    chk("loss_err_50", o_err, 1);
    chk("loss_unlocked", o_locked, 0);
    for (int i = 61; i <= 70; i++) begin
      cycle(1, i, 0, 1);
      if (i == 61) chk("loss_60_no_err", o_err, 0);
    end
    cycle(0, 0, 0, 1);
    chk("relock_err_cnt", o_err_cnt, 3);
    chk("relock_locked", o_locked, 1);

    // Gapped valid with a mid-stream clear hitting a word in S2
    val = 71;
    for (int k = 0; k < 40; k++) begin
      if (k == 21) begin
        cycle(0, 0, 1, 1);
        chk("clr_err_cnt", o_err_cnt, 0);
        chk("clr_word_cnt", o_word_cnt, 0);
        chk("clr_locked", o_locked, 0);
      end else if (k % 2 == 0) begin
        cycle(1, val, 0, 1);
        val++;
      end else begin
        cycle(0, 0, 0, 1);
      end
    end
    chk("gap_relocked", o_locked, 1);
    chk("gap_err_cnt", o_err_cnt, 0);

    // Async reset mid-stream
    for (int i = 100; i < 110; i++) cycle(1, i, 0, 1);
    do_reset(3);
    for (int i = 110; i < 120; i++) cycle(1, i, 0, 1);
    cycle(0, 0, 0, 1);
    chk("rst_mid_word_cnt", o_word_cnt, 10);
    chk("rst_mid_err_cnt", o_err_cnt, 0);
    chk("rst_mid_locked", o_locked, 1);

    // Randomized traffic against the model
    last = 119;
    w = 0;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 149) == 0);
      if (rv) begin
        case ($urandom_range(0, 19))
          0:       w = $urandom_range(0, 255);
          1:       w = last;
          default: w = (last + 1) % 256;
        endcase
        last = w;
      end
      cycle(rv, w, rc, 1);
    end

`ifdef GRAY_HD_CHECK_EN
    // Hamming-distance flag: 5 -> 7 differs in two bits, repeated 7 differs in none
    do_reset(1);
    cycle(1, 5, 0, 1);
    cycle(1, 7, 0, 1);
    cycle(1, 7, 0, 1);
    chk("hd_5_7", o_hd_err, 1);
    chk("hd_5_7_bin", o_bin, 7);
    cycle(0, 0, 0, 1);
    chk("hd_7_7", o_hd_err, 1);
    for (int i = 8; i < 20; i++) begin
      cycle(1, i, 0, 1);
      if (i > 9) chk("hd_ramp", o_hd_err, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
